// File: rtl/vend_pkg.sv
// Shared types and coin values for the vending-machine controller.
// Coin values are expressed in nickel units.
package vend_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    VEND    = 2'd2,
    CHANGE  = 2'd3
  } vend_state_t;

  localparam int NICKEL_VAL  = 1;
  localparam int DIME_VAL    = 2;
  localparam int QUARTER_VAL = 5;

endpackage

// File: rtl/vend_ctrl.sv
// Vending-machine controller: accumulates coin credit, requests a dispense at PRICE,
// then pays back any excess credit one nickel per cycle.
module vend_ctrl
  import vend_pkg::*;
#(
  parameter int PRICE    = 3,
  parameter int CREDIT_W = 4,
  parameter int SALES_W  = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                coin_n,
  input  logic                coin_d,
  input  logic                coin_q,
  input  logic                cancel,
  input  logic                vend_ack,
  output logic                vend_req,
  output logic                change_nickel,
  output logic                coin_reject,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy,
  output logic [SALES_W-1:0]  sales_count
);

  // Worst case credit is PRICE-1 plus a quarter, so PRICE+4 must fit in the register.
  if (PRICE < 1 || PRICE + 4 > 2**CREDIT_W - 1) begin : g_bad_params
    $error("vend_ctrl: PRICE=%0d is illegal for CREDIT_W=%0d", PRICE, CREDIT_W);
  end

  localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);

  vend_state_t         state_reg;
  vend_state_t         state_next;
  logic [CREDIT_W-1:0] credit_next;
  logic [SALES_W-1:0]  sales_next;
  logic                reject_next;
  logic                nickel_next;

  logic                coin_any;
  logic                coin_extra;
  logic [CREDIT_W-1:0] coin_val;
  logic [CREDIT_W-1:0] credit_sum;
  logic [CREDIT_W-1:0] credit_left;

  always_comb begin
    coin_any    = coin_n | coin_d | coin_q;
    // Any second coin in the same cycle loses to the higher-priority one.
    coin_extra  = (coin_q & (coin_d | coin_n)) | (coin_d & coin_n);
    coin_val    = coin_q ? CREDIT_W'(QUARTER_VAL) :
                  coin_d ? CREDIT_W'(DIME_VAL)    :
                  coin_n ? CREDIT_W'(NICKEL_VAL)  : '0;
    credit_sum  = credit + coin_val;
    credit_left = credit - PRICE_C;

    state_next  = state_reg;
    credit_next = credit;
    sales_next  = sales_count;
    reject_next = 1'b0;
    nickel_next = 1'b0;

    case (state_reg)
      IDLE, COLLECT: begin
        if (state_reg == COLLECT && cancel) begin
          state_next  = CHANGE;
          reject_next = coin_any;
        end else if (coin_any) begin
          credit_next = credit_sum;
          reject_next = coin_extra;
          state_next  = (credit_sum >= PRICE_C) ? VEND : COLLECT;
        end
      end
      VEND: begin
        reject_next = coin_any;
        if (vend_ack) begin
          credit_next = credit_left;
          sales_next  = sales_count + SALES_W'(1);
          state_next  = (credit_left != '0) ? CHANGE : IDLE;
        end
      end
      CHANGE: begin
        reject_next = coin_any;
        // The final pay-out cycle still sits in CHANGE; IDLE follows once credit reads zero.
        if (credit != '0) begin
          credit_next = credit - CREDIT_W'(1);
          nickel_next = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      credit        <= '0;
      sales_count   <= '0;
      vend_req      <= 1'b0;
      change_nickel <= 1'b0;
      coin_reject   <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state_reg     <= state_next;
      credit        <= credit_next;
      sales_count   <= sales_next;
      vend_req      <= (state_next == VEND);
      change_nickel <= nickel_next;
      coin_reject   <= reject_next;
      busy          <= (state_next == VEND) || (state_next == CHANGE);
    end
  end

endmodule

// File: tb/tb_vend_ctrl.sv
// Scenario bench for vend_ctrl (PRICE=3, CREDIT_W=4, SALES_W=2): expected outputs are queued
// as each cycle's stimulus is driven and compared one cycle later.
module tb_vend_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       coin_n = 1'b0, coin_d = 1'b0, coin_q = 1'b0, cancel = 1'b0, vend_ack = 1'b0;
  logic       vend_req, change_nickel, coin_reject, busy;
  logic [3:0] credit;
  logic [1:0] sales_count;

  vend_ctrl #(.PRICE(3), .CREDIT_W(4), .SALES_W(2)) dut (
    .clk(clk), .reset(reset), .coin_n(coin_n), .coin_d(coin_d), .coin_q(coin_q),
    .cancel(cancel), .vend_ack(vend_ack), .vend_req(vend_req), .change_nickel(change_nickel),
    .coin_reject(coin_reject), .credit(credit), .busy(busy), .sales_count(sales_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       vr;
    logic       cn;
    logic       cr;
    logic [3:0] credit;
    logic       busy;
    logic [1:0] sales;
  } obs_t;

  // Stimulus bits: {reset, coin_n, coin_d, coin_q, cancel, vend_ack}
  typedef logic [5:0] stim_t;
  localparam stim_t S_IDLE = 6'b000000, S_ACK = 6'b000001, S_CAN = 6'b000010, S_Q = 6'b000100,
                    S_D = 6'b001000, S_N = 6'b010000, S_RST = 6'b100000;

  obs_t  sb[$];
  stim_t stim_q[$];
  obs_t  exp_tbl[$];
  int    checks = 0;
  int    errors = 0;
  obs_t  exp_v, act_v;
  int    row;

  function automatic obs_t mk(input int vr, cn, cr, cred, bz, sales);
    obs_t o;
    o.vr = 1'(vr); o.cn = 1'(cn); o.cr = 1'(cr);
    o.credit = 4'(cred); o.busy = 1'(bz); o.sales = 2'(sales);
    return o;
  endfunction

  function automatic obs_t observe();
    return {vend_req, change_nickel, coin_reject, credit, busy, sales_count};
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("vr=%b cn=%b rej=%b credit=%0d busy=%b sales=%0d",
                     o.vr, o.cn, o.cr, o.credit, o.busy, o.sales);
  endfunction

  function automatic void add(input stim_t s, input obs_t e);
    stim_q.push_back(s);
    exp_tbl.push_back(e);
  endfunction

  task automatic drive(input stim_t s, input obs_t e);
    @(negedge clk);
    {reset, coin_n, coin_d, coin_q, cancel, vend_ack} = s;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    add(S_RST | S_Q | S_N, mk(0,0,0,0,0,0));
    add(S_RST,             mk(0,0,0,0,0,0));
    add(S_IDLE,            mk(0,0,0,0,0,0));
    row = 0;
    while (stim_q.size() > 0) begin
      drive(stim_q.pop_front(), exp_tbl.pop_front());
      @(posedge clk); #1;
      exp_v = sb.pop_front(); act_v = observe(); checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL reset[%0d]: got %s, expected %s", row, fmt(act_v), fmt(exp_v));
      end
      $display("reset[%0d]: %s", row, fmt(act_v));
      row++;
    end
  endtask

  task automatic test_nickels();
    add(S_N,    mk(0,0,0,1,0,0));
    add(S_N,    mk(0,0,0,2,0,0));
    add(S_N,    mk(1,0,0,3,1,0));
    add(S_IDLE, mk(1,0,0,3,1,0));
    add(S_ACK,  mk(0,0,0,0,0,1));
    add(S_IDLE, mk(0,0,0,0,0,1));
    row = 0;
    while (stim_q.size() > 0) begin
      drive(stim_q.pop_front(), exp_tbl.pop_front());
      @(posedge clk); #1;
      exp_v = sb.pop_front(); act_v = observe(); checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL nickels[%0d]: got %s, expected %s", row, fmt(act_v), fmt(exp_v));
      end
      $display("nickels[%0d]: %s", row, fmt(act_v));
      row++;
    end
  endtask

  task automatic test_quarter_change();
    add(S_Q,         mk(1,0,0,5,1,1));
    add(S_N,         mk(1,0,1,5,1,1));  // coin during VEND rejected
    add(S_ACK,       mk(0,0,0,2,1,2));
    add(S_D,         mk(0,1,1,1,1,2));  // coin during CHANGE rejected
    add(S_ACK,       mk(0,1,0,0,1,2));  // ack while vend_req=0 ignored
    add(S_IDLE,      mk(0,0,0,0,0,2));
    row = 0;
    while (stim_q.size() > 0) begin
      drive(stim_q.pop_front(), exp_tbl.pop_front());
      @(posedge clk); #1;
      exp_v = sb.pop_front(); act_v = observe(); checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL quarter[%0d]: got %s, expected %s", row, fmt(act_v), fmt(exp_v));
      end
      $display("quarter[%0d]: %s", row, fmt(act_v));
      row++;
    end
  endtask

  task automatic test_cancel();
    add(S_D,         mk(0,0,0,2,0,2));
    add(S_CAN,       mk(0,0,0,2,1,2));
    add(S_IDLE,      mk(0,1,0,1,1,2));
    add(S_IDLE,      mk(0,1,0,0,1,2));
    add(S_IDLE,      mk(0,0,0,0,0,2));
    add(S_N,         mk(0,0,0,1,0,2));
    add(S_N | S_CAN, mk(0,0,1,1,1,2));  // coin with cancel rejected, not credited
    add(S_IDLE,      mk(0,1,0,0,1,2));
    add(S_IDLE,      mk(0,0,0,0,0,2));
    add(S_CAN,       mk(0,0,0,0,0,2));  // cancel in IDLE does nothing
    add(S_ACK,       mk(0,0,0,0,0,2));
    row = 0;
    while (stim_q.size() > 0) begin
      drive(stim_q.pop_front(), exp_tbl.pop_front());
      @(posedge clk); #1;
      exp_v = sb.pop_front(); act_v = observe(); checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL cancel[%0d]: got %s, expected %s", row, fmt(act_v), fmt(exp_v));
      end
      $display("cancel[%0d]: %s", row, fmt(act_v));
      row++;
    end
  endtask

  task automatic test_simultaneous_reset_mid_change();
    add(S_D | S_N,       mk(0,0,1,2,0,2));
    add(S_IDLE,          mk(0,0,0,2,0,2));
    add(S_Q | S_D | S_N, mk(1,0,1,7,1,2));  // quarter wins, credit 2+5
    add(S_ACK,           mk(0,0,0,4,1,3));
    add(S_IDLE,          mk(0,1,0,3,1,3));
    add(S_IDLE,          mk(0,1,0,2,1,3));
    add(S_IDLE,          mk(0,1,0,1,1,3));
    add(S_RST,           mk(0,0,0,0,0,0));  // reset with one nickel still owed
    add(S_IDLE,          mk(0,0,0,0,0,0));
    row = 0;
    while (stim_q.size() > 0) begin
      drive(stim_q.pop_front(), exp_tbl.pop_front());
      @(posedge clk); #1;
      exp_v = sb.pop_front(); act_v = observe(); checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL simul[%0d]: got %s, expected %s", row, fmt(act_v), fmt(exp_v));
      end
      $display("simul[%0d]: %s", row, fmt(act_v));
      row++;
    end
  endtask

  task automatic test_sales_wrap();
    for (int k = 0; k < 4; k++) begin
      add(S_D,   mk(0,0,0,2,0,k));
      add(S_N,   mk(1,0,0,3,1,k));
      add(S_ACK, mk(0,0,0,0,0,(k + 1) % 4));
    end
    row = 0;
    while (stim_q.size() > 0) begin
      drive(stim_q.pop_front(), exp_tbl.pop_front());
      @(posedge clk); #1;
      exp_v = sb.pop_front(); act_v = observe(); checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL sales[%0d]: got %s, expected %s", row, fmt(act_v), fmt(exp_v));
      end
      $display("sales[%0d]: %s", row, fmt(act_v));
      row++;
    end
  endtask

  initial begin
    test_reset();
    test_nickels();
    test_quarter_change();
    test_cancel();
    test_simultaneous_reset_mid_change();
    test_sales_wrap();
    @(negedge clk);
    {reset, coin_n, coin_d, coin_q, cancel, vend_ack} = S_IDLE;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
